fifo_nway: RTL

FIFO_NWAY -- requirements
Module: fifo_nway

---
 rtl/fifo_nway.sv | 117 +++++++++++
 1 files changed

// File: rtl/fifo_nway.sv
// Multi-lane circular FIFO: up to IN_WAYS enqueues and OUT_WAYS dequeues per clock.
// Defining FIFO_NWAY_BYPASS_EN lets input lanes reach the outputs combinationally while the FIFO is empty.
module fifo_nway #(
    parameter int WIDTH    = 32,
    parameter int NUM      = 8,
    parameter int IN_WAYS  = 2,
    parameter int OUT_WAYS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      IN_flush,
    output logic [$clog2(NUM):0]      free,
    input  logic [IN_WAYS-1:0]        IN_valid,
    input  logic [IN_WAYS*WIDTH-1:0]  IN_data,
    output logic                      OUT_ready,
    output logic [OUT_WAYS-1:0]       OUT_valid,
    output logic [OUT_WAYS*WIDTH-1:0] OUT_data,
    input  logic [OUT_WAYS-1:0]       IN_ready
);

    localparam int IDX_W    = $clog2(NUM);
    localparam int CNT_W    = IDX_W + 1;
    localparam int BYP_WAYS = (IN_WAYS < OUT_WAYS) ? IN_WAYS : OUT_WAYS;

    logic [WIDTH-1:0] mem_q [NUM];
    logic [WIDTH-1:0] mem_d [NUM];
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [CNT_W-1:0] n_in;
    logic [CNT_W-1:0] n_deq;
    logic [CNT_W-1:0] n_enq;
    logic [CNT_W-1:0] n_byp;
    logic             byp_on;
    logic             run;

    assign free = CNT_W'(NUM) - count_q;

    always_comb begin
        n_in = '0;
        for (int k = 0; k < IN_WAYS; k++) begin
            n_in = n_in + CNT_W'(IN_valid[k]);
        end
    end

    always_comb begin
        byp_on = 1'b0;
`ifdef FIFO_NWAY_BYPASS_EN
        byp_on = (count_q == '0) && !IN_flush && !rst;
`endif
        OUT_valid = '0;
        OUT_data  = '0;
        for (int j = 0; j < OUT_WAYS; j++) begin
            OUT_valid[j]                = (CNT_W'(j) < count_q);
            OUT_data[j*WIDTH +: WIDTH] = mem_q[head_q + IDX_W'(j)];
        end
        if (byp_on) begin
            for (int j = 0; j < BYP_WAYS; j++) begin
                OUT_valid[j]                = IN_valid[j];
                OUT_data[j*WIDTH +: WIDTH] = IN_data[j*WIDTH +: WIDTH];
            end
        end
    end

    // Only the leading run of valid&ready lanes is consumed, keeping output order intact.
    always_comb begin
        n_deq = '0;
        run   = 1'b1;
        for (int j = 0; j < OUT_WAYS; j++) begin
            if (run && OUT_valid[j] && IN_ready[j]) begin
                n_deq = n_deq + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
        n_byp = byp_on ? n_deq : '0;
    end

    assign OUT_ready = ({1'b0, n_in} <= ({1'b0, free} + {1'b0, n_deq}));
    assign n_enq     = OUT_ready ? n_in : '0;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q + (n_deq[IDX_W-1:0] - n_byp[IDX_W-1:0]);
        tail_d  = tail_q + (n_enq[IDX_W-1:0] - n_byp[IDX_W-1:0]);
        count_d = count_q + n_enq - n_deq;
        // Bypassed lanes are never stored; later lanes pack down starting at tail.
        for (int k = 0; k < IN_WAYS; k++) begin
            if (OUT_ready && IN_valid[k] && !IN_flush && (CNT_W'(k) >= n_byp)) begin
                mem_d[tail_q + IDX_W'(k) - n_byp[IDX_W-1:0]] = IN_data[k*WIDTH +: WIDTH];
            end
        end
        if (IN_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
